// File: rtl/buffer_ctrl.sv
// buffer_ctrl: sequences one frame through the single-bit Buffer.
// A pixel stream is written in receive mode (FILL), then read back in
// address order in send mode (DRAIN), then a one-cycle done pulse (DONE).
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid is never withdrawn before that edge, data is stable while
// valid is high and ready is low.
module buffer_ctrl #(
  parameter int NPIX  = 22500,
  parameter int CNT_W = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             pix_in,
  input  logic             pix_in_valid,
  output logic             pix_in_ready,
  output logic             pix_out,
  output logic             pix_out_valid,
  input  logic             pix_out_ready,
  output logic             buf_enb,
  output logic             buf_mode,
  output logic [CNT_W-1:0] buf_cnt,
  output logic             buf_din,
  input  logic             buf_dout,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(NPIX - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] waddr;
  logic [CNT_W-1:0] raddr;
  logic             out_valid;

  // A pixel is consumed downstream this cycle.
  logic out_hs;
  // Read address may run one ahead so the next pixel lands as this one leaves.
  logic advance;

  assign out_hs    = (state == S_DRAIN) && out_valid && pix_out_ready;
  assign advance   = out_hs && (raddr < LAST);
  assign pix_out   = buf_dout;
  assign dbg_state = state;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_FILL;
      S_FILL:  if (pix_in_valid && (waddr == LAST)) state_nxt = S_DRAIN;
      S_DRAIN: if (out_hs && (raddr == LAST)) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort) state_nxt = S_IDLE;
  end

  // Write/read address counters and the output-valid flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      waddr     <= '0;
      raddr     <= '0;
      out_valid <= 1'b0;
    end else if (abort) begin
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) waddr <= '0;
        end
        S_FILL: begin
          if (pix_in_valid) begin
            if (waddr == LAST) begin
              // Frame complete: waddr parks at the last address.
              raddr     <= '0;
              out_valid <= 1'b0;
            end else begin
              waddr <= waddr + ONE;
            end
          end
        end
        S_DRAIN: begin
          if (!out_valid) begin
            // Read of address 0 was issued on the first DRAIN cycle.
            out_valid <= 1'b1;
          end else if (pix_out_ready) begin
            if (raddr == LAST) begin
              out_valid <= 1'b0;
            end else begin
              raddr <= raddr + ONE;
            end
          end
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Buffer control and stream outputs decoded from the current state.
  always_comb begin
    pix_in_ready  = 1'b0;
    pix_out_valid = 1'b0;
    buf_enb       = 1'b0;
    buf_mode      = 1'b0;
    buf_cnt       = '0;
    buf_din       = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    case (state)
      S_FILL: begin
        pix_in_ready = 1'b1;
        buf_enb      = pix_in_valid;
        buf_cnt      = waddr;
        buf_din      = pix_in;
        busy         = 1'b1;
      end
      S_DRAIN: begin
        buf_enb       = 1'b1;
        buf_mode      = 1'b1;
        busy          = 1'b1;
        pix_out_valid = out_valid;
        // Holding raddr during a stall keeps buf_dout (and pix_out) stable.
        buf_cnt       = advance ? (raddr + ONE) : raddr;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: doc/buffer_ctrl.md
# buffer_ctrl

Sequencing controller for the single-bit frame `Buffer` (150×150 binary pixels, 22500 entries). It accepts a pixel stream over a valid/ready handshake and writes it into the buffer in receive mode. It then switches the buffer to send mode and drains the frame in address order over a second valid/ready handshake, signalling completion. It sits between the pixel source and the downstream processing stage and drives every `Buffer` control port (`enb`, `mode`, `cnt`, `arrayIn`).

## Interface
- `NPIX`, 22500: pixels per frame (150×150).
- `CNT_W`, 15: address width; requires 2^CNT_W ≥ NPIX.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high; forces IDLE and clears all registers.
- `start`  in  1  begins a frame; sampled only in IDLE.
- `abort`  in  1  synchronous; returns to IDLE from any state next cycle. No `done` is issued.
- `pix_in`, `pix_in_valid`  in  1, 1  source pixel and its qualifier.
- `pix_in_ready`  out  1  controller accepts `pix_in` this cycle.
- `pix_out`  out  1  drained pixel, combinationally equal to `buf_dout`.
- `pix_out_valid`  out  1  `pix_out` holds the pixel at the current read address.
- `pix_out_ready`  in  1  downstream consumes `pix_out` this cycle.
- `buf_enb`, `buf_mode`  out  1, 1  buffer enable; mode (0 = receive/write, 1 = send/read).
- `buf_cnt`  out  CNT_W  buffer address.
- `buf_din`  out  1  write data to the buffer's `arrayIn`.
- `buf_dout`  in  1  buffer's `arrayOut`. Read latency is one cycle: the value reflects `buf_cnt` of the previous cycle while `buf_enb`=1 and `buf_mode`=1.
- `busy`  out  1  high in FILL and DRAIN.
- `done`  out  1  one-cycle pulse when the last pixel is consumed.

## Operation
- **States:** IDLE, FILL, DRAIN, DONE. Registers are `state`, `waddr`, `raddr` (both CNT_W wide) and `out_valid`.
- **IDLE**
  - Outputs: `pix_in_ready`=0, `pix_out_valid`=0, `buf_enb`=0, `busy`=0.
  - On `start`=1: go to FILL with `waddr`=0.
- **FILL**
  - Outputs: `pix_in_ready`=1, `buf_mode`=0, `buf_cnt`=`waddr`, `buf_din`=`pix_in`, `buf_enb`=`pix_in_valid`.
  - On each accept (`pix_in_valid`=1): increment `waddr`.
  - On accepting `waddr`=NPIX−1: go to DRAIN with `raddr`=0 and `out_valid`=0. `waddr` is not incremented past NPIX−1.
- **DRAIN**
  - Outputs: `buf_enb`=1, `buf_mode`=1, `pix_in_ready`=0, `pix_out_valid`=`out_valid`.
  - Address lookahead: `buf_cnt` = `raddr`+1 when `out_valid`=1, `pix_out_ready`=1 and `raddr`<NPIX−1; otherwise `buf_cnt` = `raddr`.
  - If `out_valid`=0: set `out_valid`=1 (first read has landed).
  - On a handshake (`out_valid`=1 and `pix_out_ready`=1):
    - if `raddr`=NPIX−1: go to DONE;
    - otherwise increment `raddr` and keep `out_valid`=1.
  - Stall (`pix_out_ready`=0): hold `buf_cnt`, so `buf_dout` and `pix_out` stay stable.
- **DONE:** `done`=1 and `buf_enb`=0 for one cycle, then go to IDLE unconditionally.
- `start` is ignored outside IDLE.
- `abort` has priority over every other transition.
- `reset` has priority over `abort`.
- The controller never drives `buf_cnt` ≥ NPIX.

## Timing
- **Reset values:**
  - `state`=IDLE, `waddr`=`raddr`=0, `out_valid`=0.
  - Outputs: `pix_in_ready`=0, `pix_out_valid`=0, `buf_enb`=0, `buf_mode`=0, `buf_cnt`=0, `buf_din`=0, `busy`=0, `done`=0.
- **`start` to `pix_in_ready`:** 1 cycle.
- **Last write to first output:** the last write is accepted at cycle T. DRAIN issues read 0 at T+1. `pix_out_valid` rises at T+2.
- **Drain throughput:** 1 pixel/cycle while `pix_out_ready`=1. Fill throughput: 1 pixel/cycle.
- **Frame latency:** with both streams continuous, `done` pulses NPIX+2 cycles after the last input accept.
- **`busy`** falls in the DONE cycle. The next `start` is honoured from the following IDLE cycle.
- **Abort / mid-frame reset:** buffer contents are undefined afterwards. A new frame must be fully refilled.

## Test plan
- Reset asserted mid-FILL at `waddr`=100 → all outputs return to reset values immediately. After release, `start` restarts at `waddr`=0.
- Continuous fill of 22500 pixels with pattern `pix`=address[0], then continuous drain → 22500 outputs matching the pattern in order. Exactly one `done`, 22502 cycles after the last accept.
- Random `pix_in_valid` gaps (30%) during fill → `buf_enb` high only on accepts. The final buffer image equals the source sequence.
- `pix_out_ready` held low for 5 cycles at `raddr`=1000 → `pix_out`, `pix_out_valid`=1 and `buf_cnt` stable throughout. Index 1000 is delivered once, with no skip or duplicate.
- `abort` at `raddr`=5 → IDLE next cycle, `done` never pulses, `busy`=0. `start` during FILL is ignored.
- Two back-to-back frames with different patterns → second drain returns only second-frame data. `done` pulses twice.
